refill_victim_sel: RTL

- Cache-refill victim selector. It sits directly downstream of the 8-bit pseudo-random way LFSR: it consumes the LFSR's binary way output and drives the LFSR's enable.
- On a miss request it picks the way to refill. Invalid, unlocked ways have priority; otherwise it uses a random unlocked way, with a bounded retry and a deterministic fallback.
- The chosen way is returned over a valid/ready handshake to the miss handler.

---
 rtl/refill_victim_sel.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/refill_victim_sel.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// refill_victim_sel : cache-refill victim selector (free-way first, LFSR retry)
// Rev 1.0
// ---------------------------------------------------------------------------
module refill_victim_sel #(
  parameter int NumWays  = 8,
  parameter int MaxTries = 4,
  parameter int LogWays  = $clog2(NumWays)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [NumWays-1:0] req_valid_ways_i,
  input  logic [NumWays-1:0] req_lock_ways_i,
  input  logic [LogWays-1:0] lfsr_bin_i,
  output logic               lfsr_en_o,
  output logic               vict_valid_o,
  input  logic               vict_ready_i,
  output logic [NumWays-1:0] vict_way_oh_o,
  output logic [LogWays-1:0] vict_way_bin_o,
  output logic               vict_evict_o,
  output logic               vict_none_o
);

  localparam int PadW   = 1 << LogWays;
  localparam int RetryW = (MaxTries > 1) ? $clog2(MaxTries) : 1;
  localparam logic [RetryW-1:0] RetryLast = RetryW'(MaxTries - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NumWays-1:0]  valid_ways_q, valid_ways_d;
  logic [NumWays-1:0]  lock_ways_q, lock_ways_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [NumWays-1:0]  way_oh_q, way_oh_d;
  logic [LogWays-1:0]  way_bin_q, way_bin_d;
  logic                evict_q, evict_d;
  logic                none_q, none_d;

  logic [NumWays-1:0]  elig, free;
  logic [PadW-1:0]     elig_pad;
  logic [LogWays-1:0]  free_idx, elig_idx;
  logic                cand_ok, random_mode;

  function automatic logic [LogWays-1:0] lowest_idx(input logic [NumWays-1:0] m);
    logic [LogWays-1:0] idx;
    idx = '0;
    for (int i = NumWays - 1; i >= 0; i--) begin
      if (m[i]) idx = LogWays'(i);
    end
    return idx;
  endfunction

  always_comb begin
    elig     = ~lock_ways_q;
    free     = elig & ~valid_ways_q;
    // Zero-padded so LFSR codes past the last way read as ineligible.
    elig_pad = '0;
    elig_pad[NumWays-1:0] = elig;
    free_idx = lowest_idx(free);
    elig_idx = lowest_idx(elig);
    cand_ok  = elig_pad[lfsr_bin_i];
    random_mode = (state_q == SCAN) && (free == '0) && (elig != '0);
  end

  always_comb begin
    state_d      = state_q;
    valid_ways_d = valid_ways_q;
    lock_ways_d  = lock_ways_q;
    retry_d      = retry_q;
    way_oh_d     = way_oh_q;
    way_bin_d    = way_bin_q;
    evict_d      = evict_q;
    none_d       = none_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          valid_ways_d = req_valid_ways_i;
          lock_ways_d  = req_lock_ways_i;
          retry_d      = '0;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (free != '0) begin
          way_bin_d = free_idx;
          way_oh_d  = '0;
          way_oh_d[free_idx] = 1'b1;
          evict_d   = 1'b0;
          state_d   = OUT;
        end else if (elig == '0) begin
          way_bin_d = '0;
          way_oh_d  = '0;
          evict_d   = 1'b0;
          none_d    = 1'b1;
          state_d   = OUT;
        end else if (cand_ok) begin
          way_bin_d = lfsr_bin_i;
          way_oh_d  = '0;
          way_oh_d[lfsr_bin_i] = 1'b1;
          evict_d   = 1'b1;
          state_d   = OUT;
        end else if (retry_q == RetryLast) begin
          way_bin_d = elig_idx;
          way_oh_d  = '0;
          way_oh_d[elig_idx] = 1'b1;
          evict_d   = 1'b1;
          state_d   = OUT;
        end else begin
          retry_d = retry_q + 1'b1;
        end
      end
      OUT: begin
        if (vict_ready_i) begin
          way_bin_d = '0;
          way_oh_d  = '0;
          evict_d   = 1'b0;
          none_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_ways_q <= '0;
      lock_ways_q  <= '0;
      retry_q      <= '0;
      way_oh_q     <= '0;
      way_bin_q    <= '0;
      evict_q      <= 1'b0;
      none_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_ways_q <= valid_ways_d;
      lock_ways_q  <= lock_ways_d;
      retry_q      <= retry_d;
      way_oh_q     <= way_oh_d;
      way_bin_q    <= way_bin_d;
      evict_q      <= evict_d;
      none_q       <= none_d;
    end
  end

  // Gated with reset so nothing handshakes or advances the LFSR during reset.
  assign req_ready_o    = (state_q == IDLE) && !rst_i;
  assign lfsr_en_o      = random_mode && !rst_i;
  assign vict_valid_o   = (state_q == OUT);
  assign vict_way_oh_o  = way_oh_q;
  assign vict_way_bin_o = way_bin_q;
  assign vict_evict_o   = evict_q;
  assign vict_none_o    = none_q;

  if (NumWays < 2 || NumWays > 8) begin : g_bad_num_ways
    $error("refill_victim_sel: NumWays must be in 2..8");
  end
  if (MaxTries < 1) begin : g_bad_max_tries
    $error("refill_victim_sel: MaxTries must be >= 1");
  end

  a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (vict_valid_o && !vict_ready_i) |=>
      (vict_valid_o && $stable({vict_way_oh_o, vict_way_bin_o, vict_evict_o, vict_none_o})));

  a_onehot: assert property (@(posedge clk_i) $countones(vict_way_oh_o) <= 1);

endmodule
`default_nettype wire
